dp_tx_engine: RTL and testbench

DP_TX_ENGINE -- requirements
Module: dp_tx_engine

---
 rtl/dp_tx_engine_if.sv | 36 +++
 rtl/dp_tx_engine.sv | 147 ++++++++++++++
 tb/tb_dp_tx_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_tx_engine_if.sv
// Bus bundle between the GPP / control plane and the data-plane transmit
// engine: FIFO push port, transmit grant/request handshake, the outgoing
// flit stream and FIFO status.
interface dp_tx_engine_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   gpp_wr_en;
  logic [DATA_W-1:0]      gpp_wr_data;
  logic                   data_tx_flag;
  logic                   data_tx_req;
  logic [ID_W+DATA_W-1:0] data_tx_packet;
  logic                   data_tx_valid;
  logic                   data_tx_complete_flag;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow_err;

  // Producer / control-plane side.
  modport master (
    output gpp_wr_en, gpp_wr_data, data_tx_flag,
    input  data_tx_req, data_tx_packet, data_tx_valid, data_tx_complete_flag,
    input  fifo_count, fifo_full, fifo_empty, overflow_err
  );

  // Transmit engine side.
  modport slave (
    input  gpp_wr_en, gpp_wr_data, data_tx_flag,
    output data_tx_req, data_tx_packet, data_tx_valid, data_tx_complete_flag,
    output fifo_count, fifo_full, fifo_empty, overflow_err
  );
endinterface

// File: rtl/dp_tx_engine.sv
// Data-plane transmit engine: a TX FIFO filled by the GPP, drained one
// packet (dest word + PKT_LEN payload words) at a time once the control
// plane grants transmission. Output flits are {dest, field}.
module dp_tx_engine #(
  parameter int DATA_W  = 16,
  parameter int ID_W    = 16,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] node_id,
  dp_tx_engine_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [BW-1:0]          r_beat;
  logic [BW-1:0]          w_beat_next;
  logic [ID_W-1:0]        r_dest;
  logic [ID_W+DATA_W-1:0] r_packet;
  logic [ID_W+DATA_W-1:0] w_packet_next;
  logic                   r_valid;
  logic                   w_valid_next;

  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_dest_load;
  logic                   w_req;
  logic [DATA_W-1:0]      w_head;
  logic [DATA_W-1:0]      w_node_ext;

  assign w_full     = (r_count == CW'(DEPTH));
  // A push while full is dropped regardless of a same-cycle pop.
  assign w_push     = bus.gpp_wr_en & ~w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_node_ext = DATA_W'(node_id);
  assign w_req      = (r_state == IDLE) && (r_count >= CW'(PKT_LEN + 1));

  assign bus.data_tx_req           = w_req;
  assign bus.data_tx_packet        = r_packet;
  assign bus.data_tx_valid         = r_valid;
  assign bus.data_tx_complete_flag = (r_state == DONE);
  assign bus.fifo_count            = r_count;
  assign bus.fifo_full             = w_full;
  assign bus.fifo_empty            = (r_count == '0);
  assign bus.overflow_err          = r_ovf;

  // FIFO storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.gpp_wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.gpp_wr_en && w_full) r_ovf <= 1'b1;
    end
  end

  // Packet FSM next state, FIFO pop and next registered flit.
  always_comb begin
    w_state_next  = r_state;
    w_beat_next   = r_beat;
    w_pop         = 1'b0;
    w_dest_load   = 1'b0;
    w_valid_next  = 1'b0;
    w_packet_next = '0;
    unique case (r_state)
      IDLE: begin
        if (w_req && bus.data_tx_flag) begin
          w_pop        = 1'b1;
          w_dest_load  = 1'b1;
          w_state_next = HEADER;
        end
      end
      HEADER: begin
        if (bus.data_tx_flag) begin
          w_valid_next  = 1'b1;
          w_packet_next = {r_dest, w_node_ext};
          w_beat_next   = '0;
          w_state_next  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (bus.data_tx_flag) begin
          // The beat after the last payload word emits nothing and closes
          // the packet, so the complete pulse follows the last flit.
          if (r_beat == BW'(PKT_LEN)) begin
            w_state_next = DONE;
          end else begin
            w_pop         = 1'b1;
            w_valid_next  = 1'b1;
            w_packet_next = {r_dest, w_head};
            w_beat_next   = r_beat + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state, beat counter, latched destination and output flit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_dest   <= '0;
      r_packet <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_beat   <= w_beat_next;
      r_packet <= w_packet_next;
      r_valid  <= w_valid_next;
      if (w_dest_load) r_dest <= w_head[ID_W-1:0];
    end
  end
endmodule

// File: tb/tb_dp_tx_engine.sv
// Self-checking bench for dp_tx_engine: a queue-based packet model for the
// default configuration checked every cycle, directed scenarios with
// literal expectations, random traffic, and a second 32/8/PKT_LEN=2 instance.
`timescale 1ns/1ps
module tb_dp_tx_engine;
  localparam int DW  = 16, IW  = 16, DEP  = 16, PL  = 4;
  localparam int DWB = 32, IWB = 8,  DEPB = 4,  PLB = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IW-1:0]  node_id   = 16'h0005;
  logic [IWB-1:0] node_id_b = 8'h5A;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dp_tx_engine_if #(.DATA_W(DW),  .ID_W(IW),  .DEPTH(DEP))  bus_a ();
  dp_tx_engine_if #(.DATA_W(DWB), .ID_W(IWB), .DEPTH(DEPB)) bus_b ();

  dp_tx_engine #(.DATA_W(DW), .ID_W(IW), .DEPTH(DEP), .PKT_LEN(PL)) u_dut_a (
    .clk(clk), .rst(rst), .node_id(node_id), .bus(bus_a)
  );
  dp_tx_engine #(.DATA_W(DWB), .ID_W(IWB), .DEPTH(DEPB), .PKT_LEN(PLB)) u_dut_b (
    .clk(clk), .rst(rst), .node_id(node_id_b), .bus(bus_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  // FIFO is a queue; a packet in flight is described by how many of its
  // PKT_LEN+1 flits have been emitted. m_mode: 0 waiting, 1 sending,
  // 2 complete-pulse cycle.
  logic [DW-1:0]    mq[$];
  int               m_mode = 0;
  int               m_sent = 0;
  logic [IW-1:0]    m_dest = '0;
  logic             m_valid = 1'b0;
  logic [IW+DW-1:0] m_pkt = '0;
  logic             m_ovf = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_sent = 0; m_valid = 1'b0; m_pkt = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [DW-1:0] w;
    bit was_full;
    was_full = (mq.size() == DEP);
    m_valid  = 1'b0;
    m_pkt    = '0;
    case (m_mode)
      0: if (mq.size() >= PL + 1 && bus_a.data_tx_flag) begin
           w = mq.pop_front();
           m_dest = w[IW-1:0];
           m_mode = 1;
           m_sent = 0;
         end
      1: if (bus_a.data_tx_flag) begin
           if (m_sent == 0) begin
             m_valid = 1'b1; m_pkt = {m_dest, DW'(node_id)}; m_sent = 1;
           end else if (m_sent <= PL) begin
             w = mq.pop_front();
             m_valid = 1'b1; m_pkt = {m_dest, w}; m_sent++;
           end else begin
             m_mode = 2;
           end
         end
      default: m_mode = 0;
    endcase
    if (bus_a.gpp_wr_en) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(bus_a.gpp_wr_data);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare of instance A ----------------
  logic [IW+DW-1:0] mon_a[$];
  int               cpl_a = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("valid",    64'(bus_a.data_tx_valid),         64'(m_valid));
      check("packet",   64'(bus_a.data_tx_packet),        64'(m_pkt));
      check("complete", 64'(bus_a.data_tx_complete_flag), 64'(m_mode == 2));
      check("req",      64'(bus_a.data_tx_req),           64'(m_mode == 0 && mq.size() >= PL + 1));
      check("count",    64'(bus_a.fifo_count),            64'(mq.size()));
      check("full",     64'(bus_a.fifo_full),             64'(mq.size() == DEP));
      check("empty",    64'(bus_a.fifo_empty),            64'(mq.size() == 0));
      check("overflow", 64'(bus_a.overflow_err),          64'(m_ovf));
      if (bus_a.data_tx_valid) mon_a.push_back(bus_a.data_tx_packet);
      if (bus_a.data_tx_complete_flag) cpl_a++;
    end
  end

  // ---------------- monitor of instance B ----------------
  logic [IWB+DWB-1:0] mon_b[$];
  int                 cpl_b  = 0;
  bit                 b_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus_b.data_tx_valid) mon_b.push_back(bus_b.data_tx_packet);
      if (bus_b.data_tx_complete_flag) cpl_b++;
    end
  end

  task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit fl);
    bus_a.gpp_wr_en = wr; bus_a.gpp_wr_data = d; bus_a.data_tx_flag = fl;
    @(negedge clk);
  endtask

  task automatic cb(input bit wr, input logic [DWB-1:0] d, input bit fl);
    bus_b.gpp_wr_en = wr; bus_b.gpp_wr_data = d; bus_b.data_tx_flag = fl;
    @(negedge clk);
  endtask

  // Instance B: two back-to-back packets through a 4-deep FIFO (pointer wrap).
  initial begin : b_proc
    logic [IWB+DWB-1:0] exp_b [6];
    exp_b = '{40'h33_0000005A, 40'h33_CAFE0001, 40'h33_CAFE0002,
              40'h44_0000005A, 40'h44_BEEF0003, 40'h44_BEEF0004};
    bus_b.gpp_wr_en = 1'b0; bus_b.gpp_wr_data = '0; bus_b.data_tx_flag = 1'b0;
    wait (rst == 1'b1);
    @(negedge clk);
    cb(1'b1, 32'hFFFFFF33, 1'b1);
    cb(1'b1, 32'hCAFE0001, 1'b1);
    cb(1'b1, 32'hCAFE0002, 1'b1);
    cb(1'b0, '0, 1'b1);
    cb(1'b0, '0, 1'b1);
    cb(1'b1, 32'h12345644, 1'b1);
    cb(1'b1, 32'hBEEF0003, 1'b1);
    cb(1'b1, 32'hBEEF0004, 1'b1);
    repeat (12) cb(1'b0, '0, 1'b1);
    check("b_flit_count", 64'(mon_b.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < mon_b.size()) check("b_flit", 64'(mon_b[i]), 64'(exp_b[i]));
    check("b_complete_pulses", 64'(cpl_b), 64'd2);
    check("b_count_end", 64'(bus_b.fifo_count), 64'd0);
    check("b_overflow", 64'(bus_b.overflow_err), 64'd0);
    b_done = 1'b1;
  end

  // ---------------- main stimulus for instance A ----------------
  initial begin : main
    logic [31:0] exp_t1 [5];
    logic [31:0] exp_t3 [5];
    bit seen_dead;
    exp_t1 = '{32'h00090005, 32'h000900A1, 32'h000900A2, 32'h000900A3, 32'h000900A4};
    exp_t3 = '{32'h000C0005, 32'h000C00B1, 32'h000C00B2, 32'h000C00B3, 32'h000C00B4};
    bus_a.gpp_wr_en = 1'b0; bus_a.gpp_wr_data = '0; bus_a.data_tx_flag = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    check("rst_empty", 64'(bus_a.fifo_empty),    64'd1);
    check("rst_full",  64'(bus_a.fifo_full),     64'd0);
    check("rst_req",   64'(bus_a.data_tx_req),   64'd0);
    check("rst_count", 64'(bus_a.fifo_count),    64'd0);
    check("rst_valid", 64'(bus_a.data_tx_valid), 64'd0);
    @(negedge clk);

    // Basic packet with grant held
    mon_a.delete(); cpl_a = 0;
    cyc(1'b1, 16'h0009, 1'b1);
    cyc(1'b1, 16'h00A1, 1'b1);
    cyc(1'b1, 16'h00A2, 1'b1);
    cyc(1'b1, 16'h00A3, 1'b1);
    cyc(1'b1, 16'h00A4, 1'b1);
    repeat (12) cyc(1'b0, '0, 1'b1);
    check("t1_flit_count", 64'(mon_a.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < mon_a.size()) check("t1_flit", 64'(mon_a[i]), 64'(exp_t1[i]));
    check("t1_complete", 64'(cpl_a), 64'd1);
    check("t1_count", 64'(bus_a.fifo_count), 64'd0);

    // Request threshold
    mon_a.delete(); cpl_a = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'($urandom), 1'b0);
    check("t2_req_at_4", 64'(bus_a.data_tx_req), 64'd0);
    cyc(1'b1, DW'($urandom), 1'b0);
    check("t2_req_at_5", 64'(bus_a.data_tx_req), 64'd1);
    repeat (10) cyc(1'b0, '0, 1'b1);
    check("t2_flit_count", 64'(mon_a.size()), 64'd5);
    check("t2_complete", 64'(cpl_a), 64'd1);

    // Grant dropped for 3 cycles after the 2nd payload flit
    mon_a.delete(); cpl_a = 0;
    cyc(1'b1, 16'h000C, 1'b0);
    cyc(1'b1, 16'h00B1, 1'b0);
    cyc(1'b1, 16'h00B2, 1'b0);
    cyc(1'b1, 16'h00B3, 1'b0);
    cyc(1'b1, 16'h00B4, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1);
    check("t3_before_stall", 64'(bus_a.data_tx_packet), 64'h000C00B2);
    cyc(1'b0, '0, 1'b0);
    check("t3_stall_valid",  64'(bus_a.data_tx_valid),  64'd0);
    check("t3_stall_packet", 64'(bus_a.data_tx_packet), 64'd0);
    repeat (2) cyc(1'b0, '0, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b1);
    check("t3_flit_count", 64'(mon_a.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < mon_a.size()) check("t3_flit", 64'(mon_a[i]), 64'(exp_t3[i]));
    check("t3_complete", 64'(cpl_a), 64'd1);

    // Fill to full, overflow on the 17th push
    mon_a.delete(); cpl_a = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'($urandom_range(0, 16'h7FFF)), 1'b0);
    check("t4_full", 64'(bus_a.fifo_full), 64'd1);
    check("t4_ovf_before", 64'(bus_a.overflow_err), 64'd0);
    cyc(1'b1, 16'hDEAD, 1'b0);
    check("t4_ovf_after", 64'(bus_a.overflow_err), 64'd1);
    check("t4_count", 64'(bus_a.fifo_count), 64'd16);
    repeat (40) cyc(1'b0, '0, 1'b1);
    seen_dead = 1'b0;
    foreach (mon_a[i]) if (mon_a[i][DW-1:0] == 16'hDEAD) seen_dead = 1'b1;
    check("t4_dropped_word_sent", 64'(seen_dead), 64'd0);
    check("t4_left_count", 64'(bus_a.fifo_count), 64'd1);
    check("t4_complete", 64'(cpl_a), 64'd3);

    // Reset in the middle of a payload
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_valid",    64'(bus_a.data_tx_valid),         64'd0);
    check("t5_packet",   64'(bus_a.data_tx_packet),        64'd0);
    check("t5_complete", 64'(bus_a.data_tx_complete_flag), 64'd0);
    check("t5_count",    64'(bus_a.fifo_count),            64'd0);
    check("t5_overflow", 64'(bus_a.overflow_err),          64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    mon_a.delete(); cpl_a = 0;
    repeat (10) cyc(1'b0, '0, 1'b1);
    check("t5_post_flits",    64'(mon_a.size()),          64'd0);
    check("t5_post_complete", 64'(cpl_a),                 64'd0);
    check("t5_post_req",      64'(bus_a.data_tx_req),     64'd0);
    check("t5_post_count",    64'(bus_a.fifo_count),      64'd0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++)
      cyc(($urandom % 3) == 0, DW'($urandom), ($urandom % 5) != 0);
    repeat (20) cyc(1'b0, '0, 1'b1);

    for (int i = 0; i < 400 && !b_done; i++) @(negedge clk);
    check("b_finished", 64'(b_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
